hdlc_frame_ctrl: RTL
====================

// Module: hdlc_frame_ctrl
// PURPOSE
//  Frame controller after the HDLC flag delineation stage. Takes sop/eop/byte strobes from delineation
//  and tracks frame state. Enforces min/max frame length and flags aborted frames. Re-times the byte
//  stream so the last payload byte carries the end marker, then drives a clean framed stream plus
//  status counters to the frame buffer.
// PARAMETERS
//  MIN_LEN   4     minimum legal frame length in bytes (incl. FCS bytes); shorter frames are errored
//  MAX_LEN   1500  maximum legal frame length in bytes; longer frames are truncated, errored, dropped
//  CNT_W     16    width of frame length counter and of status counters
// PORTS
//  clk         in   1      rising-edge clock, single domain
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      byte strobe from delineation; inputs below are ignored when 0
//  sop_in      in   1      qualifies in_valid: data_in is first byte of a new frame
//  eop_in      in   1      qualifies in_valid: closing flag seen; data_in (8'h7E) is NOT payload
//  data_in     in   8      byte from delineation
//  out_valid   out  1      out_data valid this cycle (one-cycle pulse per byte)
//  out_sop     out  1      with out_valid: first byte of frame
//  out_eop     out  1      with out_valid: last byte of frame
//  out_err     out  1      with out_eop: frame bad (short, long, aborted, or FCS when enabled)
//  out_data    out  8      payload byte
//  busy        out  1      1 while state != IDLE
//  ok_cnt      out  CNT_W  count of frames closed with out_err=0; wraps
//  err_cnt     out  CNT_W  count of frames closed with out_err=1; wraps
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; hold register empty; length counter 0.
//  - One-byte hold register. A byte is output only when its successor (next byte or eop) arrives.
//    Output registered: byte k is presented 1 clk after the in_valid cycle of byte k+1 or eop.
//  - States: IDLE, RECV, DROP.
//    IDLE: in_valid&sop_in -> load hold, hold_sop=1, len=1, goto RECV. eop_in or plain bytes ignored.
//    RECV: in_valid & plain byte -> emit hold (out_sop=hold_sop), load new byte, len+=1.
//          len+1 > MAX_LEN -> emit hold with out_eop=1, out_err=1; discard byte; goto DROP.
//          in_valid&eop_in -> emit hold with out_eop=1. out_err=1 if len<MIN_LEN (or FCS bad); goto IDLE.
//          in_valid&sop_in (no eop: abort) -> emit hold with out_eop=1, out_err=1. Load new byte as
//          first of the next frame; len=1; stay RECV.
//    DROP: discard all bytes; eop_in -> IDLE; sop_in -> load as new frame, len=1, goto RECV.
//  - sop_in and eop_in both set in one cycle: treat as eop (close current), then start new frame
//    with data_in only if data_in != 8'h7E; else IDLE.
//  - 1-byte frame (sop then eop): single output cycle, out_sop=out_eop=1, out_err=1 when MIN_LEN>1.
//  - Counters update on the cycle out_eop is driven. ok_cnt+1 if out_err=0, else err_cnt+1.
//    The DROP path counts once, at truncation.
//  - Length counter saturates at MAX_LEN+1; never wraps.
//  - rst_n low mid-frame: immediate clear; no eop emitted; counters cleared.
// CONFIGURATION
//  HDLC_FCS_CHECK_EN defined: CRC-16/X.25 (poly 0x1021 reflected, init 0xFFFF) computed over every
//    frame byte including the two FCS bytes. At eop, a residue != 16'hF0B8 forces out_err=1.
//    The CRC is reset at every frame start. FCS bytes are still forwarded. Zero added latency.
//  Not defined: no CRC logic; out_err only from length/abort/truncation rules.
// TESTING
//  T1 sop 0x11, bytes 0x22,0x33,0x44, eop -> 4 out bytes 11..44; sop on 11, eop on 44, err=0; ok_cnt=1
//  T2 sop 0xAA, 0xBB, eop (MIN_LEN=4) -> 2 bytes; eop on BB with err=1; err_cnt=1; ok_cnt unchanged
//  T3 MAX_LEN=8, 10 bytes then eop -> 8 bytes out; eop+err on 8th; bytes 9,10 dropped; err_cnt+1; IDLE
//  T4 sop 0x01,0x02,0x03, sop 0x10,0x20,0x30,0x40, eop -> frame1 eop+err on 0x03; frame2 4 bytes ok
//  T5 rst_n low after 3 bytes of a frame -> all outputs 0 at once; next sop frame starts clean, len=1
//  T6 (FCS_EN) frame 0x01,0x02 + correct FCS -> err=0; flip one FCS bit -> err=1, err_cnt+1

Source files
------------

// File: rtl/hdlc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hdlc_frame_ctrl
// Description : HDLC frame controller. It enforces frame length limits,
//               flags aborted frames, and re-times bytes so that the last
//               payload byte carries the end marker.
//               Optional macro: HDLC_FCS_CHECK_EN enables the CRC-16/X.25
//               residue check.
// Revision    : 1.0 - initial release
// ============================================================================
module hdlc_frame_ctrl #(
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 1500,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sop_in,
    input  logic             eop_in,
    input  logic [7:0]       data_in,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_err,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] c_MIN_LEN = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] c_MAX_LEN = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_LEN_SAT = CNT_W'(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] c_LEN_ONE = CNT_W'(1);
    localparam logic [7:0]       c_FLAG    = 8'h7E;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_hold_data;
    logic             r_hold_sop;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_nxt;
    logic             r_out_valid, r_out_sop, r_out_eop, r_out_err;
    logic [7:0]       r_out_data;
    logic [CNT_W-1:0] r_ok_cnt, r_err_cnt;
    logic             w_emit, w_eop, w_err, w_load, w_new;
    logic             w_fcs_bad;
    logic             w_restart;

`ifdef HDLC_FCS_CHECK_EN
    logic [15:0] r_crc;

    // Reflected CRC-16/X.25 (poly 0x8408), LSB first; good residue 0xF0B8
    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    assign w_fcs_bad = (r_crc != 16'hF0B8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= 16'hFFFF;
        end else if (w_load) begin
            r_crc <= f_crc_byte(w_new ? 16'hFFFF : r_crc, data_in);
        end
    end
`else
    assign w_fcs_bad = 1'b0;
`endif

    // A combined sop+eop only opens a new frame when its byte is not the flag itself
    assign w_restart = sop_in && (data_in != c_FLAG);

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_emit      = 1'b0;
        w_eop       = 1'b0;
        w_err       = 1'b0;
        w_load      = 1'b0;
        w_new       = 1'b0;
        if (in_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (sop_in && (!eop_in || w_restart)) begin
                        w_load = 1'b1;
                        w_new  = 1'b1;
                    end
                end
                S_RECV: begin
                    if (eop_in) begin
                        w_emit = 1'b1;
                        w_eop  = 1'b1;
                        w_err  = (r_len < c_MIN_LEN) || w_fcs_bad;
                        if (w_restart) begin
                            w_load = 1'b1;
                            w_new  = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else if (sop_in) begin
                        w_emit = 1'b1;
                        w_eop  = 1'b1;
                        w_err  = 1'b1;
                        w_load = 1'b1;
                        w_new  = 1'b1;
                    end else if (r_len >= c_MAX_LEN) begin
                        w_emit      = 1'b1;
                        w_eop       = 1'b1;
                        w_err       = 1'b1;
                        w_len_nxt   = c_LEN_SAT;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_emit    = 1'b1;
                        w_load    = 1'b1;
                        w_len_nxt = r_len + c_LEN_ONE;
                    end
                end
                S_DROP: begin
                    if (eop_in) begin
                        if (w_restart) begin
                            w_load = 1'b1;
                            w_new  = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else if (sop_in) begin
                        w_load = 1'b1;
                        w_new  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
            if (w_new) begin
                w_len_nxt   = c_LEN_ONE;
                w_state_nxt = S_RECV;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_hold_data <= 8'h00;
            r_hold_sop  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= 8'h00;
            r_ok_cnt    <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_out_valid <= w_emit;
            r_out_sop   <= w_emit && r_hold_sop;
            r_out_eop   <= w_eop;
            r_out_err   <= w_err;
            r_out_data  <= w_emit ? r_hold_data : 8'h00;
            if (w_load) begin
                r_hold_data <= data_in;
                r_hold_sop  <= w_new;
            end
            if (w_eop) begin
                if (w_err) r_err_cnt <= r_err_cnt + c_LEN_ONE;
                else       r_ok_cnt  <= r_ok_cnt + c_LEN_ONE;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign out_err   = r_out_err;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    assign ok_cnt    = r_ok_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
